// File: rtl/event_ts_pkg.sv
// Shared types and constants for the event timestamper slice.
package event_ts_pkg;
  localparam int TS_W_DEF   = 32;
  localparam int DROP_CNT_W = 16;

  typedef logic [TS_W_DEF-1:0] ts_t;
endpackage

// File: rtl/ts_sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop frees a slot for a same-cycle write when full.
module ts_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             push, pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: the output is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/event_timestamper.sv
// Synchronises event_in, stamps each rising edge with time_in and queues stamps downstream.
// Optional EVENT_TIMESTAMPER_DROP_CNT_EN adds a saturating drop_count output.
module event_timestamper
  import event_ts_pkg::*;
#(
  parameter int TS_W        = TS_W_DEF,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TS_W-1:0]          time_in,
  input  logic                     event_in,
  input  logic                     clear,
  output logic [TS_W-1:0]          ts_data,
  output logic                     ts_valid,
  input  logic                     ts_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
`ifdef EVENT_TIMESTAMPER_DROP_CNT_EN
  , output logic [DROP_CNT_W-1:0]  drop_count
`endif
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_evt, prev, edge_det, full, empty, drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], event_in};
      prev <= sync_evt;
    end
  end

  assign sync_evt = sync[SYNC_STAGES-1];
  assign edge_det = sync_evt & ~prev;
  // A full FIFO only loses the edge if nothing leaves in the same cycle.
  assign drop     = edge_det && full && !ts_ready && !clear;
  assign ts_valid = !empty;

  ts_sync_fifo #(.WIDTH(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (edge_det),
    .wr_data (time_in),
    .rd_en   (ts_ready),
    .rd_data (ts_data),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      overflow <= 1'b0;
    else if (clear) overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
  end

`ifdef EVENT_TIMESTAMPER_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        drop_count <= '0;
    else if (clear)                   drop_count <= '0;
    else if (drop && !(&drop_count))  drop_count <= drop_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_event_timestamper.sv
// Directed bench for event_timestamper; time_in is a cycle counter zeroed by reset.
module tb_event_timestamper;
  logic        clk = 1'b0;
  logic        reset, event_in, clear, ts_ready;
  logic [31:0] time_in, tcount, ts_data;
  logic        ts_valid, overflow;
  logic [3:0]  fifo_count;
`ifdef EVENT_TIMESTAMPER_DROP_CNT_EN
  logic [15:0] drop_count;
`endif
  int          checks = 0, failures = 0;
  logic [31:0] exp_ts [9];

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) tcount <= '0;
    else       tcount <= tcount + 1;
  assign time_in = tcount;

  event_timestamper dut (
    .clk        (clk),
    .reset      (reset),
    .time_in    (time_in),
    .event_in   (event_in),
    .clear      (clear),
    .ts_data    (ts_data),
    .ts_valid   (ts_valid),
    .ts_ready   (ts_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
`ifdef EVENT_TIMESTAMPER_DROP_CNT_EN
    , .drop_count (drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Three-cycle pulse slot; returns just after the write edge of this pulse.
  task automatic pulse();
    event_in = 1'b1;
    step(1);
    event_in = 1'b0;
    step(2);
  endtask

  initial begin
    reset = 1'b1; event_in = 1'b0; clear = 1'b0; ts_ready = 1'b0;
    step(3);
    chk("rst_valid", {31'd0, ts_valid}, 0);
    chk("rst_count", {28'd0, fifo_count}, 0);
    chk("rst_ovf",   {31'd0, overflow}, 0);
    chk("rst_data",  ts_data, 0);
    reset = 1'b0;

    // First capture: raised after posedge 10 -> written at posedge 13 with stamp 12.
    step(10);
    event_in = 1'b1;
    step(2);
    chk("lat_count_pre", {28'd0, fifo_count}, 0);
    step(1);
    chk("lat_valid", {31'd0, ts_valid}, 1);
    chk("lat_count", {28'd0, fifo_count}, 1);
    chk("lat_data",  ts_data, 32'd12);
    step(18);
    event_in = 1'b0;
    step(3);
    chk("level_count", {28'd0, fifo_count}, 1);
    ts_ready = 1'b1;
    step(1);
    ts_ready = 1'b0;
    chk("pop1_valid", {31'd0, ts_valid}, 0);

    // Nine pulses into an 8-deep FIFO with no draining.
    for (int i = 0; i < 9; i++) begin
      exp_ts[i] = tcount + 2;
      pulse();
      chk("fill_count", {28'd0, fifo_count}, (i < 8) ? i + 1 : 8);
      chk("fill_ovf",   {31'd0, overflow}, (i == 8) ? 1 : 0);
    end
`ifdef EVENT_TIMESTAMPER_DROP_CNT_EN
    chk("drop_cnt1", {16'd0, drop_count}, 1);
`endif
    for (int i = 0; i < 3; i++) begin
      chk("fill_order", ts_data, exp_ts[i]);
      ts_ready = 1'b1;
      step(1);
      ts_ready = 1'b0;
    end
    chk("pre_clr_count", {28'd0, fifo_count}, 5);
    chk("pre_clr_ovf",   {31'd0, overflow}, 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_count", {28'd0, fifo_count}, 0);
    chk("clr_ovf",   {31'd0, overflow}, 0);
    chk("clr_valid", {31'd0, ts_valid}, 0);
`ifdef EVENT_TIMESTAMPER_DROP_CNT_EN
    chk("clr_drop", {16'd0, drop_count}, 0);
`endif

    // Full FIFO with a pop on the same edge as a new write: nothing lost.
    for (int i = 0; i < 8; i++) begin
      exp_ts[i] = tcount + 2;
      pulse();
    end
    chk("full_count", {28'd0, fifo_count}, 8);
    exp_ts[8] = tcount + 2;
    event_in = 1'b1;
    step(1);
    event_in = 1'b0;
    step(1);
    ts_ready = 1'b1;
    step(1);
    ts_ready = 1'b0;
    chk("wp_count", {28'd0, fifo_count}, 8);
    chk("wp_ovf",   {31'd0, overflow}, 0);
    chk("wp_head",  ts_data, exp_ts[1]);
`ifdef EVENT_TIMESTAMPER_DROP_CNT_EN
    chk("wp_drop", {16'd0, drop_count}, 0);
`endif

    // Drain with ready toggling; data must hold while stalled.
    for (int i = 1; i < 9; i++) begin
      chk("drain_data", ts_data, exp_ts[i]);
      step(1);
      chk("stall_data", ts_data, exp_ts[i]);
      ts_ready = 1'b1;
      step(1);
      ts_ready = 1'b0;
    end
    chk("drain_valid", {31'd0, ts_valid}, 0);
    chk("drain_count", {28'd0, fifo_count}, 0);

    // clear on the write edge discards that edge.
    event_in = 1'b1;
    step(1);
    event_in = 1'b0;
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(3);
    chk("clr_edge_count", {28'd0, fifo_count}, 0);

    // Async reset mid-burst, with event_in held high across release.
    pulse(); pulse(); pulse();
    chk("burst_count", {28'd0, fifo_count}, 3);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_count", {28'd0, fifo_count}, 0);
    chk("arst_valid", {31'd0, ts_valid}, 0);
    chk("arst_data",  ts_data, 0);
    chk("arst_ovf",   {31'd0, overflow}, 0);
    event_in = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    chk("hi_rel_count", {28'd0, fifo_count}, 1);
    chk("hi_rel_data",  ts_data, 32'd2);
    step(10);
    chk("hi_rel_once", {28'd0, fifo_count}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
